rf_access_ctrl: RTL
===================

// Module: rf_access_ctrl
// PURPOSE
//  Owns the address/write ports of the 2-read/1-write CPU register file (sync-addressed read, 1-cycle latency).
//  Clears all 32 registers after reset, passes ID-stage reads and WB-stage writes through in normal run,
//  and shares the RF with the debug monitor port over a req/ack handshake, stalling the pipeline while it does.
//  Enforces x0 semantics: writes to x0 are dropped, reads of x0 return 0.
// PARAMETERS
//  ADR_W  5   register address width
//  DAT_W  32  register data width
//  NREG   32  number of registers cleared by init (2**ADR_W)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      reset, asynchronous, active-high
//  cpu_radr1  in   ADR_W  ID read address, port 1
//  cpu_radr2  in   ADR_W  ID read address, port 2
//  cpu_rdata1 out  DAT_W  read data 1 (valid cycle after address; 0 for x0)
//  cpu_rdata2 out  DAT_W  read data 2 (valid cycle after address; 0 for x0)
//  cpu_wadr   in   ADR_W  WB write address
//  cpu_wdata  in   DAT_W  WB write data
//  cpu_wen    in   1      WB write enable
//  cpu_stall  out  1      pipeline must hold: controller owns RF
//  init_done  out  1      RF clear finished
//  dbg_req    in   1      debug access request (4-phase, level)
//  dbg_we     in   1      1=write, 0=read; stable while dbg_req high
//  dbg_adr    in   ADR_W  debug register address
//  dbg_wdata  in   DAT_W  debug write data
//  dbg_ack    out  1      debug access complete
//  dbg_rdata  out  DAT_W  debug read data, valid while dbg_ack high
//  ram_radr1/ram_radr2 out ADR_W, ram_rdata1/ram_rdata2 in DAT_W, ram_wadr out ADR_W,
//  ram_wdata out DAT_W, ram_wen out 1: RF RAM ports
// BEHAVIOUR
//  Reset: state INIT, clr_cnt=0, init_done=0, cpu_stall=1, dbg_ack=0, dbg_rdata=0, rdaddr-copy regs=0.
//  States: INIT, RUN, DBG, DBG_RD, ACK. All ram_* combinational from state; ram_wen=0 while rst high.
//  INIT: ram_wen=1, ram_wadr=clr_cnt, ram_wdata=0; clr_cnt++ each clk; at clr_cnt==NREG-1 -> RUN,
//   init_done=1 (registered, stays 1 until reset). 32 write cycles total. cpu_stall=1.
//  RUN: cpu_stall=0; ram_radr*=cpu_radr*; ram_w*=cpu_w*, ram_wen=cpu_wen & (cpu_wadr!=0).
//   If dbg_req=1 -> DBG; the cpu write in that same cycle is still performed.
//  DBG: cpu_stall=1, cpu_wen ignored (CPU holds WB). Write: ram_wen=(dbg_adr!=0), ram_wadr=dbg_adr,
//   ram_wdata=dbg_wdata -> ACK. Read: ram_radr1=dbg_adr -> DBG_RD.
//  DBG_RD: dbg_rdata <= (dbg_adr==0)?0:ram_rdata1 -> ACK.
//  ACK: dbg_ack=1, cpu_stall=1; stay until dbg_req=0, then -> RUN (dbg_ack low in RUN).
//  Port 1 read address is cpu_radr1 in every state except DBG-read, so cpu_rdata is valid on the
//   first RUN cycle after a stall (RF address re-latched during last stall cycle).
//  Port 2 address is always cpu_radr2.
//  Read masking: controller registers ram_radr1/2 each clk; cpu_rdataN = (reg_adrN==0)?0:ram_rdataN.
//  Latency: debug read req seen at n -> ack at n+3; debug write -> ack at n+2.
//  dbg_req high during INIT: held pending, serviced on first RUN cycle.
//  rst mid-operation (any state): immediate INIT, ack/rdata/init_done cleared, full clear restarts.
//  dbg_rdata holds last read value until next debug read or reset.
// TESTING
//  Release rst -> ram_wen=1 for 32 clks, wadr 0..31, wdata 0; then init_done=1, cpu_stall=0.
//  cpu_wen x5=0xDEADBEEF; next clk radr1=5 -> cpu_rdata1=0xDEADBEEF one clk later.
//  cpu_wen x0=0x1234 -> ram_wen stays 0; radr2=0 -> cpu_rdata2=0.
//  dbg read x5 -> stall 3 clks, ack with dbg_rdata=0xDEADBEEF, ack held until req drops.
//  dbg write x7=0xA5A5A5A5 raised with cpu_wen x6=0x11 -> x6=0x11 and x7=0xA5A5A5A5.
//  rst pulse in DBG_RD -> dbg_ack=0, init_done=0, 32-clk clear reruns; dbg_req held in INIT -> ack after clear.

Source files
------------

// File: rtl/rf_access_ctrl.sv
// Register-file access controller: clears the RF after reset, routes CPU
// reads/writes in normal run, and time-shares the RF with a debug port
// through a 4-phase req/ack handshake while stalling the pipeline.
// Register x0 is never written and always reads as zero.
module rf_access_ctrl #(
    parameter int unsigned ADR_W = 5,
    parameter int unsigned DAT_W = 32,
    parameter int unsigned NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    // CPU pipeline side
    input  logic [ADR_W-1:0] cpu_radr1,
    input  logic [ADR_W-1:0] cpu_radr2,
    output logic [DAT_W-1:0] cpu_rdata1,
    output logic [DAT_W-1:0] cpu_rdata2,
    input  logic [ADR_W-1:0] cpu_wadr,
    input  logic [DAT_W-1:0] cpu_wdata,
    input  logic             cpu_wen,
    output logic             cpu_stall,
    output logic             init_done,
    // Debug monitor side
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [ADR_W-1:0] dbg_adr,
    input  logic [DAT_W-1:0] dbg_wdata,
    output logic             dbg_ack,
    output logic [DAT_W-1:0] dbg_rdata,
    // Register-file RAM side
    output logic [ADR_W-1:0] ram_radr1,
    output logic [ADR_W-1:0] ram_radr2,
    input  logic [DAT_W-1:0] ram_rdata1,
    input  logic [DAT_W-1:0] ram_rdata2,
    output logic [ADR_W-1:0] ram_wadr,
    output logic [DAT_W-1:0] ram_wdata,
    output logic             ram_wen
);

    typedef enum logic [2:0] {
        StInit,
        StRun,
        StDbg,
        StDbgRd,
        StAck
    } state_e;

    localparam logic [ADR_W-1:0] LastReg = ADR_W'(NREG - 1);

    state_e           state_q, state_d;
    logic [ADR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             init_done_q, init_done_d;
    logic [DAT_W-1:0] dbg_rdata_q, dbg_rdata_d;
    // Copies of the addresses the RAM latched, used to mask x0 reads
    logic [ADR_W-1:0] radr1_q, radr2_q;
    logic             wen_raw;

    // State register, clear counter, debug read data and read-address copies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StInit;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            dbg_rdata_q <= '0;
            radr1_q     <= '0;
            radr2_q     <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            dbg_rdata_q <= dbg_rdata_d;
            radr1_q     <= ram_radr1;
            radr2_q     <= ram_radr2;
        end
    end

    // Next-state logic and RAM port steering, decoded from the current state
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        dbg_rdata_d = dbg_rdata_q;
        ram_radr1   = cpu_radr1;
        ram_radr2   = cpu_radr2;
        ram_wadr    = cpu_wadr;
        ram_wdata   = cpu_wdata;
        wen_raw     = 1'b0;
        cpu_stall   = 1'b1;
        dbg_ack     = 1'b0;

        unique case (state_q)
            StInit: begin
                wen_raw   = 1'b1;
                ram_wadr  = clr_cnt_q;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + ADR_W'(1);
                if (clr_cnt_q == LastReg) begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end
            end
            StRun: begin
                cpu_stall = 1'b0;
                wen_raw   = cpu_wen && (cpu_wadr != '0);
                // The CPU write of this cycle still lands before the debug takes over
                if (dbg_req) begin
                    state_d = StDbg;
                end
            end
            StDbg: begin
                // CPU holds its WB write during a stall, so cpu_wen is ignored here
                if (dbg_we) begin
                    ram_wadr  = dbg_adr;
                    ram_wdata = dbg_wdata;
                    wen_raw   = (dbg_adr != '0);
                    state_d   = StAck;
                end else begin
                    ram_radr1 = dbg_adr;
                    state_d   = StDbgRd;
                end
            end
            StDbgRd: begin
                dbg_rdata_d = (dbg_adr == '0) ? '0 : ram_rdata1;
                state_d     = StAck;
            end
            StAck: begin
                dbg_ack = 1'b1;
                if (!dbg_req) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // Never write the RAM while reset is asserted, even mid-cycle
    assign ram_wen    = wen_raw & ~rst;
    assign init_done  = init_done_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign cpu_rdata1 = (radr1_q == '0) ? '0 : ram_rdata1;
    assign cpu_rdata2 = (radr2_q == '0) ? '0 : ram_rdata2;

endmodule
